// File: rtl/mips_shift_pkg.sv
// mips_shift_pkg: shared op codes, FSM encoding and width defaults for the shift path
package mips_shift_pkg;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SHAMT_WIDTH = 5;
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step_unit.sv
// shift_step_unit: combinational shift by a small amount with op-dependent fill
module shift_step_unit
    import mips_shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
    input  logic [1:0]             op,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] k,
    output logic [DATA_WIDTH-1:0]  result
);
    logic signed [DATA_WIDTH-1:0] sra;
    always_comb begin
        sra    = $signed(data) >>> k;
        result = op == OP_SLL ? data << k : op == OP_SRA ? sra : data >> k;
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA controller with busy/done handshake
module shift_sequencer
    import mips_shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH,
    parameter int STEP        = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_start,
    input  logic [1:0]             in_op,
    input  logic                   in_variable,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic [DATA_WIDTH-1:0]  in_rs_data,
    input  logic [DATA_WIDTH-1:0]  in_rt_data,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [DATA_WIDTH-1:0]  out_result
);
    localparam logic [SHAMT_WIDTH-1:0] STEP_W = SHAMT_WIDTH'(STEP);
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] data_q, data_nx, result_q, result_nx, step_out;
    logic [1:0] op_q, op_nx;
    logic [SHAMT_WIDTH-1:0] rem_q, rem_nx, amt, k;
    logic unused_rs;
    assign unused_rs = ^in_rs_data[DATA_WIDTH-1:SHAMT_WIDTH];
    shift_step_unit #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH)) u_step (
        .op(op_q),
        .data(data_q),
        .k(k),
        .result(step_out)
    );
    always_comb begin
        amt       = in_op == OP_RSVD ? '0 : in_variable ? in_rs_data[SHAMT_WIDTH-1:0] : in_shamt;
        k         = rem_q < STEP_W ? rem_q : STEP_W;
        state_nx  = state;
        data_nx   = data_q;
        op_nx     = op_q;
        rem_nx    = rem_q;
        result_nx = result_q;
        case (state)
            IDLE: if (in_start) begin
                data_nx  = in_rt_data;
                op_nx    = in_op;
                rem_nx   = amt;
                state_nx = amt == '0 ? DONE : SHIFT;
                result_nx = amt == '0 ? in_rt_data : result_q;
            end
            SHIFT: begin
                data_nx   = step_out;
                rem_nx    = rem_q - k;
                state_nx  = rem_nx == '0 ? DONE : SHIFT;
                result_nx = rem_nx == '0 ? step_out : result_q;
            end
            default: state_nx = IDLE;
        endcase
    end
    // result is loaded on the edge entering DONE so it is valid alongside out_done
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state    <= state_nx;
            data_q   <= data_nx;
            op_q     <= op_nx;
            rem_q    <= rem_nx;
            result_q <= result_nx;
        end
    end
    assign out_busy   = state != IDLE;
    assign out_done   = state == DONE;
    assign out_result = result_q;
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller for the MIPS ALU shift path (SLL/SRL/SRA and the variable forms SLLV/SRLV/SRAV).
- Selects the shift amount from either the instruction shamt field or rs[4:0].
- Iterates the shift STEP bits per cycle, then returns the result with a busy/done handshake.
- Sits beside the ALU. out_busy drives the pipeline stall logic while a shift is in flight.

Parameters:
- DATA_WIDTH, 32, width of the operand and result.
- SHAMT_WIDTH, 5, width of the shift amount.
- STEP, 1, bits shifted per cycle. Legal values: 1, 2, 4, 8, 16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_start  in  1  request a shift. Sampled only in IDLE.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- in_variable  in  1  amount source: 1 = in_rs_data[4:0], 0 = in_shamt.
- in_shamt  in  SHAMT_WIDTH  instruction shamt field.
- in_rs_data  in  DATA_WIDTH  rs register value. Only bits [4:0] are used.
- in_rt_data  in  DATA_WIDTH  value to be shifted.
- out_busy  out  1  high in SHIFT and DONE.
- out_done  out  1  one-cycle pulse when the result is valid.
- out_result  out  DATA_WIDTH  shifted value. Holds until the next accepted start.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - On reset: state = IDLE, out_busy = 0, out_done = 0, out_result = 0, internal registers = 0.
  - Reset asserted mid-operation aborts the shift. The next cycle shows the reset values.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - On in_start = 1, latch in_rt_data, in_op and amt = in_variable ? in_rs_data[4:0] : in_shamt.
  - If in_op = 11, force amt = 0. The result is then the unshifted value.
  - If amt = 0, go to DONE. Otherwise go to SHIFT.
  - in_start = 0: remain in IDLE.
- SHIFT:
  - Each cycle: k = min(STEP, remaining).
  - Apply the shift by k:
    - SLL fills with zeros.
    - SRL fills with zeros.
    - SRA fills with the original bit DATA_WIDTH-1.
  - Update remaining -= k.
  - If the new remaining = 0, go to DONE.
- DONE:
  - out_done = 1 for exactly one cycle, and out_result is loaded with the final value in the same cycle.
  - Next state is IDLE.
- Latency for a start sampled at edge 0: out_done is high in cycle 1 + ceil(amt/STEP). For amt = 0 it is cycle 1.
- Handshake:
  - in_start while out_busy = 1 is ignored. No queuing, no error.
  - Inputs other than in_start are don't-care after the start is accepted.
- Boundaries:
  - amt = 31 with STEP = 1 gives 31 SHIFT cycles.
  - Only rs[4:0] is used. Upper rs bits never affect the amount.
  - The final step is truncated when remaining < STEP, so no overshoot.
  - Each out_done pulse is followed by at least one IDLE cycle.
- out_result keeps its last value through IDLE and SHIFT. It updates only in DONE.

Decomposition:
- Package mips_shift_pkg holds:
  - the op codes OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_RSVD = 2'b11;
  - the state encoding IDLE/SHIFT/DONE;
  - the DATA_WIDTH/SHAMT_WIDTH defaults.
- One sub-module, shift_step_unit, is natural: a combinational shift by k ≤ STEP with op-dependent fill.
- The FSM, amount selection and counters stay in shift_sequencer.

Test Plan:
- SLL, in_variable = 0, in_shamt = 4, rt = 0x00000001 -> out_done in cycle 5, result 0x00000010, out_busy high cycles 1–5.
- SRA, in_variable = 1, rs = 0xFFFFFFE3 (amt 3), rt = 0x80000000 -> done in cycle 4, result 0xF0000000. Confirms the upper rs bits are ignored.
- Zero amount (shamt = 0, rt = 0x12345678) -> done in cycle 1, result 0x12345678. Also op = 11 with shamt = 9 -> same behaviour.
- SRL, shamt = 31, rt = 0xFFFFFFFF, with extra in_start pulses at cycles 5 and 20 -> single done in cycle 32, result 0x00000001, extra starts ignored.
- Reset asserted in cycle 3 of SLL 10 -> cycle 4: busy = 0, done = 0, result = 0. A new SLL 1 of 0x3 then gives 0x6 in cycle 2 after its start.
- STEP = 4 build, SLL 7 of 0x1 -> 2 SHIFT cycles (4 + 3), done in cycle 3, result 0x00000080.
